// File: rtl/rv_dpram_arb.sv
// Dual-master arbiter for a simple dual-port RAM (one write, one read port).
// Same-cycle write-to-read forwarding is enabled by defining RV_DPRAM_ARB_FWD_EN.
module rv_dpram_arb #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             m0_req,
  input  logic             m0_we,
  input  logic [AW-1:0]    m0_addr,
  input  logic [WIDTH-1:0] m0_wdata,
  output logic             m0_gnt,
  output logic             m0_rvalid,
  output logic [WIDTH-1:0] m0_rdata,
  input  logic             m1_req,
  input  logic             m1_we,
  input  logic [AW-1:0]    m1_addr,
  input  logic [WIDTH-1:0] m1_wdata,
  output logic             m1_gnt,
  output logic             m1_rvalid,
  output logic [WIDTH-1:0] m1_rdata,
  output logic             ram_wena,
  output logic [AW-1:0]    ram_addra,
  output logic [WIDTH-1:0] ram_dina,
  output logic             ram_renb,
  output logic [AW-1:0]    ram_addrb,
  input  logic [WIDTH-1:0] ram_doutb
);

  logic wc0, wc1, rc0, rc1;
  logic wg0, wg1, rg0, rg1;
  logic wptr_q, rptr_q;
  logic rv0_q, rv1_q;
  logic [WIDTH-1:0] rsp;

  assign wc0 = rst_n & m0_req & m0_we;
  assign wc1 = rst_n & m1_req & m1_we;
  assign rc0 = rst_n & m0_req & ~m0_we;
  assign rc1 = rst_n & m1_req & ~m1_we;

  assign wg0 = wc0 & (~wc1 | ~wptr_q);
  assign wg1 = wc1 & (~wc0 | wptr_q);
  assign rg0 = rc0 & (~rc1 | ~rptr_q);
  assign rg1 = rc1 & (~rc0 | rptr_q);

  assign m0_gnt = wg0 | rg0;
  assign m1_gnt = wg1 | rg1;

  // Priority pointers flip only when both masters contend for the port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
    end else begin
      if (wc0 && wc1) wptr_q <= ~wptr_q;
      if (rc0 && rc1) rptr_q <= ~rptr_q;
    end
  end

  // Write port mux from the granted writer.
  always_comb begin
    ram_wena  = 1'b0;
    ram_addra = '0;
    ram_dina  = '0;
    unique case (1'b1)
      wg0: begin
        ram_wena  = 1'b1;
        ram_addra = m0_addr;
        ram_dina  = m0_wdata;
      end
      wg1: begin
        ram_wena  = 1'b1;
        ram_addra = m1_addr;
        ram_dina  = m1_wdata;
      end
      default: ;
    endcase
  end

  // Read port mux from the granted reader.
  always_comb begin
    ram_renb  = 1'b0;
    ram_addrb = '0;
    unique case (1'b1)
      rg0: begin
        ram_renb  = 1'b1;
        ram_addrb = m0_addr;
      end
      rg1: begin
        ram_renb  = 1'b1;
        ram_addrb = m1_addr;
      end
      default: ;
    endcase
  end

  // Track which master owns the read returning next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rv0_q <= 1'b0;
      rv1_q <= 1'b0;
    end else begin
      rv0_q <= rg0;
      rv1_q <= rg1;
    end
  end

`ifdef RV_DPRAM_ARB_FWD_EN
  logic             fwd_q;
  logic [WIDTH-1:0] fwd_data_q;

  // Capture write data when it collides with the read address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_q      <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      fwd_q      <= ram_wena & ram_renb & (ram_addra == ram_addrb);
      fwd_data_q <= ram_dina;
    end
  end

  assign rsp = fwd_q ? fwd_data_q : ram_doutb;
`else
  assign rsp = ram_doutb;
`endif

  assign m0_rdata = rv0_q ? rsp : '0;
  assign m1_rdata = rv1_q ? rsp : '0;
  assign m0_rvalid = rv0_q;
  assign m1_rvalid = rv1_q;

endmodule

// File: tb/tb_rv_dpram_arb.sv
// Directed bench for rv_dpram_arb with a behavioural 1-cycle RAM.
// Honours RV_DPRAM_ARB_FWD_EN for the collision case.
module tb_rv_dpram_arb;
  localparam int WIDTH = 32;
  localparam int AW = 10;

  logic clk = 1'b0;
  logic rst_n;
  logic m0_req, m0_we, m1_req, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [WIDTH-1:0] m0_wdata, m1_wdata;
  logic m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [WIDTH-1:0] m0_rdata, m1_rdata;
  logic ram_wena, ram_renb;
  logic [AW-1:0] ram_addra, ram_addrb;
  logic [WIDTH-1:0] ram_dina;
  logic [WIDTH-1:0] ram_doutb = '0;
  logic [WIDTH-1:0] mem [1024] = '{default: '0};

  int tests = 0;
  int fails = 0;
  logic [WIDTH-1:0] exp_col;
  logic [3:0] gpat;

  always #5 clk = ~clk;

  rv_dpram_arb dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt),
    .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt),
    .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_wena(ram_wena), .ram_addra(ram_addra),
    .ram_dina(ram_dina), .ram_renb(ram_renb),
    .ram_addrb(ram_addrb), .ram_doutb(ram_doutb)
  );

  always @(posedge clk) begin
    if (ram_wena) mem[ram_addra] <= ram_dina;
    if (ram_renb) ram_doutb <= mem[ram_addrb];
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    m0_req = 1; m0_we = 1; m0_addr = 10'h3; m0_wdata = 32'hdead;
    m1_req = 1; m1_we = 0; m1_addr = 10'h4;
    #2;
    chk("rst_m0_gnt", 32'(m0_gnt), 32'd0);
    chk("rst_m1_gnt", 32'(m1_gnt), 32'd0);
    chk("rst_wena", 32'(ram_wena), 32'd0);
    chk("rst_renb", 32'(ram_renb), 32'd0);
    tick();
    tick();
    chk("rst_m0_rvalid", 32'(m0_rvalid), 32'd0);
    chk("rst_m1_rvalid", 32'(m1_rvalid), 32'd0);
    chk("rst_m1_rdata", m1_rdata, 32'd0);
    idle();
    rst_n = 1'b1;

    m0_req = 1; m0_we = 1;
    m0_addr = 10'h010; m0_wdata = 32'hA5A5A5A5;
    #1;
    chk("w1_m0_gnt", 32'(m0_gnt), 32'd1);
    chk("w1_m1_gnt", 32'(m1_gnt), 32'd0);
    chk("w1_wena", 32'(ram_wena), 32'd1);
    chk("w1_addra", 32'(ram_addra), 32'h010);
    chk("w1_dina", ram_dina, 32'hA5A5A5A5);
    chk("w1_renb", 32'(ram_renb), 32'd0);
    tick();
    chk("w1_wptr", 32'(dut.wptr_q), 32'd0);

    m0_req = 1; m0_we = 1; m0_addr = 10'h030; m0_wdata = 32'h11;
    m1_req = 1; m1_we = 1; m1_addr = 10'h031; m1_wdata = 32'h22;
    for (int i = 0; i < 4; i++) begin
      #1;
      gpat[i] = m0_gnt;
      chk("rr_excl", 32'(m0_gnt ^ m1_gnt), 32'd1);
      tick();
    end
    chk("rr_pattern_m0", 32'(gpat), 32'b0101);
    idle();
    #1;
    chk("idle_wena", 32'(ram_wena), 32'd0);
    chk("idle_addra", 32'(ram_addra), 32'd0);
    chk("idle_dina", ram_dina, 32'd0);

    tick();
    m1_req = 1; m1_we = 0; m1_addr = 10'h010;
    #1;
    chk("r1_m1_gnt", 32'(m1_gnt), 32'd1);
    chk("r1_renb", 32'(ram_renb), 32'd1);
    chk("r1_addrb", 32'(ram_addrb), 32'h010);
    tick();
    idle();
    chk("r1_m1_rvalid", 32'(m1_rvalid), 32'd1);
    chk("r1_m1_rdata", m1_rdata, 32'hA5A5A5A5);
    chk("r1_m0_rvalid", 32'(m0_rvalid), 32'd0);
    chk("r1_m0_rdata", m0_rdata, 32'd0);
    tick();
    chk("r1_m1_rvalid_end", 32'(m1_rvalid), 32'd0);
    chk("r1_m1_rdata_end", m1_rdata, 32'd0);

    m0_req = 1; m0_we = 1; m0_addr = 10'h020; m0_wdata = 32'h12345678;
    m1_req = 1; m1_we = 0; m1_addr = 10'h020;
    #1;
    chk("col_m0_gnt", 32'(m0_gnt), 32'd1);
    chk("col_m1_gnt", 32'(m1_gnt), 32'd1);
    tick();
    idle();
`ifdef RV_DPRAM_ARB_FWD_EN
    exp_col = 32'h12345678;
`else
    exp_col = 32'h00000000;
`endif
    chk("col_m1_rvalid", 32'(m1_rvalid), 32'd1);
    chk("col_m1_rdata", m1_rdata, exp_col);
    m0_req = 1; m0_we = 0; m0_addr = 10'h020;
    tick();
    idle();
    chk("col_after_m0_rdata", m0_rdata, 32'h12345678);

    m0_req = 1; m0_we = 0; m0_addr = 10'h030;
    m1_req = 1; m1_we = 0; m1_addr = 10'h031;
    #1;
    chk("b2b_first_m0", 32'(m0_gnt), 32'd1);
    chk("b2b_first_m1", 32'(m1_gnt), 32'd0);
    tick();
    m0_req = 0;
    #1;
    chk("b2b_second_m1", 32'(m1_gnt), 32'd1);
    chk("b2b_rv0", 32'(m0_rvalid), 32'd1);
    chk("b2b_rd0", m0_rdata, 32'h11);
    chk("b2b_rv1_early", 32'(m1_rvalid), 32'd0);
    tick();
    idle();
    chk("b2b_rv1", 32'(m1_rvalid), 32'd1);
    chk("b2b_rd1", m1_rdata, 32'h22);
    chk("b2b_rv0_end", 32'(m0_rvalid), 32'd0);
    chk("b2b_rptr", 32'(dut.rptr_q), 32'd1);

    tick();
    m0_req = 1; m0_we = 0; m0_addr = 10'h010;
    #1;
    chk("rr_m0_gnt", 32'(m0_gnt), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rr_gnt_masked", 32'(m0_gnt), 32'd0);
    tick();
    chk("rr_rv_in_rst", 32'(m0_rvalid), 32'd0);
    idle();
    rst_n = 1'b1;
    tick();
    chk("rr_rv_after", 32'(m0_rvalid), 32'd0);
    chk("rr_wptr", 32'(dut.wptr_q), 32'd0);
    chk("rr_rptr", 32'(dut.rptr_q), 32'd0);
    m0_req = 1; m0_we = 0; m0_addr = 10'h010;
    #1;
    chk("rr2_m0_gnt", 32'(m0_gnt), 32'd1);
    tick();
    idle();
    chk("rr2_rv", 32'(m0_rvalid), 32'd1);
    chk("rr2_rd", m0_rdata, 32'hA5A5A5A5);
    chk("rr2_m1_rv", 32'(m1_rvalid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rv_dpram_arb.md
RV_DPRAM_ARB -- requirements
Module: rv_dpram_arb

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width.
REQ-002 SHALL have parameter DEPTH, default 1024, RAM words; AW = ceil(log2(DEPTH)).
REQ-003 clk  input  1  single clock, all logic on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 mN_req  input  1  master N (N=0,1) request valid, held until granted.
REQ-006 mN_we  input  1  1 = write, 0 = read.
REQ-007 mN_addr  input  AW  word address.
REQ-008 mN_wdata  input  WIDTH  write data.
REQ-009 mN_gnt  output  1  request accepted this cycle (combinational).
REQ-010 mN_rvalid  output  1  read data valid for master N.
REQ-011 mN_rdata  output  WIDTH  read data.
REQ-012 ram_wena / ram_addra / ram_dina  output  1 / AW / WIDTH  RAM write port.
REQ-013 ram_renb / ram_addrb  output  1 / AW  RAM read port.
REQ-014 ram_doutb  input  WIDTH  RAM read data, registered in RAM, 1-cycle latency.

Function
REQ-015 Write arbitration and read arbitration SHALL be independent; one write and one read SHALL be grantable in the same cycle.
REQ-016 Each arbiter SHALL be round-robin with a 1-bit priority pointer naming the preferred master; only one contender -> that master granted regardless of pointer.
REQ-017 Pointer SHALL flip to the other master only when both masters contend for that port and the preferred one is granted; uncontested grants leave it unchanged.
REQ-018 A master requesting continuously SHALL be granted within 2 cycles (no starvation).
REQ-019 mN_gnt SHALL equal mN_req AND arbiter selection, same cycle, no registered delay.
REQ-020 On write grant: ram_wena=1, ram_addra/ram_dina from granted master; otherwise ram_wena=0, addra/dina=0.
REQ-021 On read grant: ram_renb=1, ram_addrb from granted master; otherwise ram_renb=0, addrb=0.
REQ-022 Read response: mN_rvalid SHALL pulse exactly 1 cycle after read grant to master N, never to the other master.
REQ-023 mN_rdata SHALL be 0 whenever mN_rvalid=0; otherwise response data per REQ-031/032.
REQ-024 Back-to-back read grants SHALL give back-to-back rvalid pulses, one per grant, in grant order.
REQ-025 Read and write same cycle from different masters to different addresses SHALL both complete with no interaction.

Reset
REQ-026 Both priority pointers SHALL reset to 0 (master 0 preferred).
REQ-027 All mN_rvalid, mN_rdata, pending-read owner and forwarding registers SHALL reset to 0.
REQ-028 Reset asserted with a read in flight SHALL discard it; no rvalid after deassertion for that read.
REQ-029 Under reset all gnt and RAM enables SHALL be 0, inputs ignored.
REQ-030 First cycle after rst_n rises SHALL arbitrate normally.

Configuration
REQ-031 With RV_DPRAM_ARB_FWD_EN defined: write and read granted same cycle to same address -> response SHALL carry the new write data (registered forward), not ram_doutb.
REQ-032 Without RV_DPRAM_ARB_FWD_EN: response SHALL always be ram_doutb (old data on same-address collision); no forwarding registers.

Verification
REQ-033 Reset, then m0 write 0xA5A5A5A5 @0x010 alone -> m0_gnt=1 same cycle, ram_wena=1, addra=0x010, dina=0xA5A5A5A5; pointer stays 0.
REQ-034 m0 and m1 both request writes continuously 4 cycles -> grants alternate m0,m1,m0,m1.
REQ-035 m1 read @0x010 after REQ-033 -> m1_rvalid=1 next cycle, m1_rdata=0xA5A5A5A5, m0_rvalid=0, m0_rdata=0.
REQ-036 Same cycle m0 write 0x12345678 @0x020 (old 0x0) and m1 read @0x020 -> rdata 0x12345678 with FWD_EN, 0x00000000 without.
REQ-037 m0 read granted, rst_n low next cycle -> no rvalid seen; after release pointers 0 and m0 read @0x010 returns 0xA5A5A5A5 one cycle later.
